// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: op and branch-condition encodings,
// the architectural flag layout, and the masked flag-update rule.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ALWAYS = 3'b000,
        EQ     = 3'b001,
        NE     = 3'b010,
        LT     = 3'b011,
        GE     = 3'b100,
        LTU    = 3'b101,
        GEU    = 3'b110,
        NEVER  = 3'b111
    } br_cond_e;

    typedef struct packed {
        logic z;
        logic c;
        logic s;
        logic v;
    } flags_t;

    // Logic ops leave C/V undefined at the ALU, so only arithmetic ops may load them.
    function automatic flags_t update_flags(input flags_t cur, input alu_op_e op,
                                            input logic z_in, input logic c_in,
                                            input logic s_in, input logic v_in);
        flags_t nxt;
        nxt   = cur;
        nxt.z = z_in;
        nxt.s = s_in;
        case (op)
            ADD, SUB: begin
                nxt.c = c_in;
                nxt.v = v_in;
            end
            default: begin
                nxt.c = cur.c;
                nxt.v = cur.v;
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition evaluator: flags plus condition code -> taken.
module br_cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    flags_t   flags_s;
    br_cond_e cond_s;

    assign flags_s = flags_t'(flags);
    assign cond_s  = br_cond_e'(cond);

    // Decode the condition; C is the borrow for unsigned compares after SUB.
    always_comb begin
        taken = 1'b0;
        case (cond_s)
            ALWAYS:  taken = 1'b1;
            EQ:      taken = flags_s.z;
            NE:      taken = ~flags_s.z;
            LT:      taken = flags_s.s ^ flags_s.v;
            GE:      taken = ~(flags_s.s ^ flags_s.v);
            LTU:     taken = flags_s.c;
            GEU:     taken = ~flags_s.c;
            NEVER:   taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage after the ALU: single-entry result register with valid/ready,
// architectural flag register, and branch resolution with same-cycle flag forwarding.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             zero_in,
    input  logic             carry_in,
    input  logic             sign_in,
    input  logic             ovf_in,
    input  logic             flag_we,
    input  logic [TAG_W-1:0] dest_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_dest,
    output logic [3:0]       flags,
    input  logic             br_req,
    input  logic [2:0]       br_cond,
    output logic             br_valid,
    output logic             br_taken
);

    logic             out_valid_r;
    logic [WIDTH-1:0] out_result_r;
    logic [TAG_W-1:0] out_dest_r;
    flags_t           flags_r;
    logic             br_valid_r;
    logic             br_taken_r;

    logic             accept_s;
    flags_t           eff_flags_s;
    logic             cond_taken_s;

    assign in_ready = ~out_valid_r | out_ready;
    assign accept_s = in_valid & in_ready;

    // Effective flags: the value the flag register takes at the next edge.
    always_comb begin
        eff_flags_s = flags_r;
        if (accept_s && flag_we) begin
            eff_flags_s = update_flags(flags_r, alu_op_e'(alu_op),
                                       zero_in, carry_in, sign_in, ovf_in);
        end else begin
            eff_flags_s = flags_r;
        end
    end

    br_cond_eval u_br_cond_eval (
        .flags (eff_flags_s),
        .cond  (br_cond),
        .taken (cond_taken_s)
    );

    // Single-entry output register; drain and reload in one cycle keeps full throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_result_r <= {WIDTH{1'b0}};
            out_dest_r   <= {TAG_W{1'b0}};
        end else if (accept_s) begin
            out_valid_r  <= 1'b1;
            out_result_r <= alu_result;
            out_dest_r   <= dest_in;
        end else if (out_ready) begin
            out_valid_r  <= 1'b0;
        end
    end

    // Architectural flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= flags_t'(4'b0000);
        end else begin
            flags_r <= eff_flags_s;
        end
    end

    // Branch result register; taken holds between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_valid_r <= 1'b0;
            br_taken_r <= 1'b0;
        end else begin
            br_valid_r <= br_req;
            if (br_req) begin
                br_taken_r <= cond_taken_s;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_dest   = out_dest_r;
    assign flags      = flags_r;
    assign br_valid   = br_valid_r;
    assign br_taken   = br_taken_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (WIDTH=8, TAG_W=3).
module tb_alu_result_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       zero_in, carry_in, sign_in, ovf_in;
    logic       flag_we;
    logic [2:0] dest_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [2:0] out_dest;
    logic [3:0] flags;
    logic       br_req;
    logic [2:0] br_cond;
    logic       br_valid;
    logic       br_taken;

    int errors = 0;
    int checks = 0;

    alu_result_stage #(.WIDTH(8), .TAG_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .zero_in    (zero_in),
        .carry_in   (carry_in),
        .sign_in    (sign_in),
        .ovf_in     (ovf_in),
        .flag_we    (flag_we),
        .dest_in    (dest_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dest   (out_dest),
        .flags      (flags),
        .br_req     (br_req),
        .br_cond    (br_cond),
        .br_valid   (br_valid),
        .br_taken   (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_alu(input logic [1:0] op, input logic [7:0] res,
                             input logic z, input logic c, input logic s, input logic v,
                             input logic we, input logic [2:0] dst);
        in_valid   = 1'b1;
        alu_op     = op;
        alu_result = res;
        zero_in    = z;
        carry_in   = c;
        sign_in    = s;
        ovf_in     = v;
        flag_we    = we;
        dest_in    = dst;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive_alu(2'b00, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7);
        out_ready = 1'b1;
        br_req = 1'b1;
        br_cond = 3'b000;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_result !== 8'h00) begin errors++; $display("FAIL reset_out_result: got %h expected 00", out_result); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
        checks++; if (br_valid !== 1'b0) begin errors++; $display("FAIL reset_br_valid: got %b expected 0", br_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        in_valid = 1'b0;
        br_req = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add;
        drive_alu(2'b00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3);
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid: got %b expected 1", out_valid); end
        checks++; if (out_result !== 8'h80) begin errors++; $display("FAIL add_out_result: got %h expected 80", out_result); end
        checks++; if (out_dest !== 3'd3) begin errors++; $display("FAIL add_out_dest: got %0d expected 3", out_dest); end
        checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL add_flags: got %b expected 0011", flags); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive_alu(2'b00, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
        drive_alu(2'b00, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        step();
        checks++; if (out_result !== 8'h80) begin errors++; $display("FAIL bp_hold_result: got %h expected 80", out_result); end
        checks++; if (out_dest !== 3'd1) begin errors++; $display("FAIL bp_hold_dest: got %0d expected 1", out_dest); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_high: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_reload_valid: got %b expected 1", out_valid); end
        checks++; if (out_result !== 8'h12) begin errors++; $display("FAIL bp_reload_result: got %h expected 12", out_result); end
        checks++; if (out_dest !== 3'd2) begin errors++; $display("FAIL bp_reload_dest: got %0d expected 2", out_dest); end
        checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL bp_flags_hold: got %b expected 0011", flags); end
        step();
    endtask

    task automatic test_flag_mask;
        drive_alu(2'b01, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4);
        step();
        checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL mask_sub_flags: got %b expected 0110", flags); end
        drive_alu(2'b10, 8'h00, 1'b1, 1'bx, 1'b0, 1'bx, 1'b1, 3'd4);
        step();
        checks++; if (flags !== 4'b1100) begin errors++; $display("FAIL mask_and_flags: got %b expected 1100", flags); end
        drive_alu(2'b11, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4);
        step();
        in_valid = 1'b0;
        checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL mask_or_flags: got %b expected 0110", flags); end
    endtask

    task automatic test_forwarding;
        checks++; if (flags[3] !== 1'b0) begin errors++; $display("FAIL fwd_old_z: got %b expected 0", flags[3]); end
        drive_alu(2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
        br_req = 1'b1;
        br_cond = 3'b001;
        step();
        in_valid = 1'b0;
        br_req = 1'b0;
        checks++; if (br_valid !== 1'b1) begin errors++; $display("FAIL fwd_br_valid: got %b expected 1", br_valid); end
        checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL fwd_br_taken: got %b expected 1", br_taken); end
        checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL fwd_flags: got %b expected 1000", flags); end
        step();
        checks++; if (br_valid !== 1'b0) begin errors++; $display("FAIL fwd_br_valid_drop: got %b expected 0", br_valid); end
        checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL fwd_br_taken_hold: got %b expected 1", br_taken); end
    endtask

    task automatic test_cond_sweep;
        logic [7:0] exp_taken;
        exp_taken = 8'b0010_1101;
        drive_alu(2'b01, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
        step();
        in_valid = 1'b0;
        checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL sweep_setup_flags: got %b expected 0110", flags); end
        for (int i = 0; i < 8; i++) begin
            br_req = 1'b1;
            br_cond = 3'(i);
            step();
            checks++; if (br_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid_%0d: got %b expected 1", i, br_valid); end
            checks++; if (br_taken !== exp_taken[i]) begin errors++; $display("FAIL sweep_taken_%0d: got %b expected %b", i, br_taken, exp_taken[i]); end
        end
        br_req = 1'b0;
        step();
    endtask

    task automatic test_flag_we0;
        drive_alu(2'b11, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5);
        step();
        in_valid = 1'b0;
        checks++; if (out_result !== 8'h00) begin errors++; $display("FAIL we0_result: got %h expected 00", out_result); end
        checks++; if (out_dest !== 3'd5) begin errors++; $display("FAIL we0_dest: got %0d expected 5", out_dest); end
        checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL we0_flags: got %b expected 0110", flags); end
        step();
    endtask

    task automatic test_midreset;
        out_ready = 1'b0;
        drive_alu(2'b00, 8'hAB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd6);
        step();
        in_valid = 1'b0;
        checks++; if (out_result !== 8'hAB) begin errors++; $display("FAIL midrst_loaded: got %h expected ab", out_result); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        checks++; if (out_result !== 8'h00) begin errors++; $display("FAIL midrst_result: got %h expected 00", out_result); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL midrst_flags: got %b expected 0000", flags); end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        alu_op = 2'b00;
        alu_result = 8'h00;
        zero_in = 1'b0;
        carry_in = 1'b0;
        sign_in = 1'b0;
        ovf_in = 1'b0;
        flag_we = 1'b0;
        dest_in = 3'd0;
        out_ready = 1'b1;
        br_req = 1'b0;
        br_cond = 3'b000;
        test_reset();
        test_add();
        test_backpressure();
        test_flag_mask();
        test_forwarding();
        test_cond_sweep();
        test_flag_we0();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
